par_to_ser_stream: RTL and testbench

PAR_TO_SER_STREAM -- requirements
Module: par_to_ser_stream

---
 rtl/par_to_ser_stream_pkg.sv | 22 ++
 rtl/par_to_ser_stream_word_buffer.sv | 40 ++++
 rtl/par_to_ser_stream.sv | 126 ++++++++++++
 tb/tb_par_to_ser_stream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/par_to_ser_stream_pkg.sv
// Shared types and constants for the parallel-to-serial stream block.
package par_to_ser_stream_pkg;

   // Default parallel word width.
   localparam int P2S_SERIAL_LEN = 8;

   // Widest word any instance may use; buffer entries are sized to this.
   localparam int P2S_MAX_W = 64;

   // Shifter FSM: empty or holding a word that is being serialised.
   typedef enum logic {
      P2S_IDLE  = 1'b0,
      P2S_SHIFT = 1'b1
   } p2s_state_e;

   // One parked word together with the bit order it was submitted with.
   typedef struct packed {
      logic [P2S_MAX_W-1:0] data;
      logic                 lsb_first;
   } p2s_entry_t;

endpackage : par_to_ser_stream_pkg

// File: rtl/par_to_ser_stream_word_buffer.sv
// One-entry holding buffer: parks the next word while the shifter is busy.
module p2s_word_buffer
   import par_to_ser_stream_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_i,
   input  p2s_entry_t wr_entry_i,
   input  logic       rd_i,
   input  logic       flush_i,
   output logic       full_o,
   output p2s_entry_t rd_entry_o
);

   logic       valid_q;
   p2s_entry_t entry_q;

   // Track occupancy; a write in the same cycle as a read refills the entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the single data entry is reset too, so a discarded word can
         // never leak out and the outputs are known straight after reset.
         valid_q <= 1'b0;
         entry_q <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (wr_i) begin
         // NOTE: state uses non-blocking assignments so every flop samples
         // the pre-edge values regardless of statement order.
         entry_q <= wr_entry_i;
         valid_q <= 1'b1;
      end else if (rd_i) begin
         valid_q <= 1'b0;
      end
   end

   assign full_o     = valid_q;
   assign rd_entry_o = entry_q;

endmodule : p2s_word_buffer

// File: rtl/par_to_ser_stream.sv
// Parallel-to-serial converter with per-word bit order, frame markers,
// downstream stall and an optional one-word holding buffer.
module par_to_ser_stream
   import par_to_ser_stream_pkg::*;
#(
   parameter int DATA_W = P2S_SERIAL_LEN,
   parameter int BUF_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_lsb_first,
   output logic              in_ready,
   input  logic              ser_en,
   output logic              serial_out,
   output logic              serial_valid,
   output logic              frame_start,
   output logic              frame_end,
   output logic              busy
);

   localparam int                CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   p2s_state_e        state_q;
   logic [DATA_W-1:0] shift_q;
   logic              lsb_q;
   logic [CNT_W-1:0]  bit_cnt_q;

   logic       buf_full;
   p2s_entry_t buf_entry;
   p2s_entry_t in_entry;
   logic       last_consume;
   logic       accept;
   logic       buf_wr;
   logic       buf_rd;

   // Handshake and buffer steering; in_ready never looks at in_valid.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned (which would infer a latch).
      last_consume = 1'b0;
      in_ready     = 1'b0;
      accept       = 1'b0;
      buf_rd       = 1'b0;
      buf_wr       = 1'b0;
      in_entry     = '{data: P2S_MAX_W'(in_data), lsb_first: in_lsb_first};

      last_consume = (state_q == P2S_SHIFT) && ser_en && (bit_cnt_q == LAST_BIT);
      in_ready     = (state_q == P2S_IDLE) || last_consume
                     || ((BUF_EN != 0) && !buf_full);
      accept       = in_valid && in_ready;
      // The parked word moves into the shifter as the last bit leaves.
      buf_rd       = last_consume && buf_full;
      // A word goes to the buffer unless it bypasses straight into the shifter.
      buf_wr       = accept && (state_q == P2S_SHIFT) && !(last_consume && !buf_full);
   end

   // Shifter FSM: load, shift on ser_en, reload or bypass at the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= P2S_IDLE;
         shift_q   <= '0;
         lsb_q     <= 1'b0;
         bit_cnt_q <= '0;
      end else begin
         case (state_q)
            P2S_IDLE: begin
               if (accept) begin
                  state_q   <= P2S_SHIFT;
                  shift_q   <= in_data;
                  lsb_q     <= in_lsb_first;
                  bit_cnt_q <= '0;
               end
            end
            P2S_SHIFT: begin
               if (ser_en) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_q <= '0;
                     if (buf_full) begin
                        shift_q <= DATA_W'(buf_entry.data);
                        lsb_q   <= buf_entry.lsb_first;
                     end else if (accept) begin
                        shift_q <= in_data;
                        lsb_q   <= in_lsb_first;
                     end else begin
                        state_q <= P2S_IDLE;
                        shift_q <= '0;
                     end
                  end else begin
                     shift_q   <= lsb_q ? (shift_q >> 1) : (shift_q << 1);
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= P2S_IDLE;
         endcase
      end
   end

   // Optional holding buffer; without it only direct loads are possible.
   if (BUF_EN != 0) begin : g_buf
      p2s_word_buffer u_buf (
         .clk        (clk),
         .rst_n      (rst_n),
         .wr_i       (buf_wr),
         .wr_entry_i (in_entry),
         .rd_i       (buf_rd),
         .flush_i    (1'b0),
         .full_o     (buf_full),
         .rd_entry_o (buf_entry)
      );
   end else begin : g_nobuf
      assign buf_full  = 1'b0;
      assign buf_entry = '0;
   end

   // Outputs decode straight from registered state, so they clear with reset.
   assign serial_valid = (state_q == P2S_SHIFT);
   assign serial_out   = serial_valid && (lsb_q ? shift_q[0] : shift_q[DATA_W-1]);
   assign frame_start  = serial_valid && (bit_cnt_q == '0);
   assign frame_end    = serial_valid && (bit_cnt_q == LAST_BIT);
   assign busy         = serial_valid || buf_full;

endmodule : par_to_ser_stream

// File: tb/tb_par_to_ser_stream.sv
// Scoreboard bench for par_to_ser_stream (DATA_W=8, BUF_EN=1).
module tb_par_to_ser_stream;

   typedef struct {
      logic b;
      logic fs;
      logic fe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_lsb_first;
   logic       in_ready;
   logic       ser_en;
   logic       serial_out;
   logic       serial_valid;
   logic       frame_start;
   logic       frame_end;
   logic       busy;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   run_len     = 0;
   int   last_run    = 0;

   par_to_ser_stream #(.DATA_W(8), .BUF_EN(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_lsb_first (in_lsb_first),
      .in_ready     (in_ready),
      .ser_en       (ser_en),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .frame_start  (frame_start),
      .frame_end    (frame_end),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected serial bits of one word, in the order it must leave the block.
   task automatic push_word(input logic [7:0] d, input logic lsb);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         e.b  = lsb ? d[i] : d[7-i];
         e.fs = (i == 0);
         e.fe = (i == 7);
         exp_q.push_back(e);
      end
   endtask

   // Present a word until it is accepted; returns at posedge+1 after acceptance.
   task automatic send(input logic [7:0] d, input logic lsb);
      int n;
      in_valid     = 1'b1;
      in_data      = d;
      in_lsb_first = lsb;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            push_word(d, lsb);
            @(posedge clk); #1;
            in_valid     = 1'b0;
            in_lsb_first = ~lsb;  // later order changes must not affect this word
            in_data      = ~d;
            return;
         end
         @(posedge clk); #1;
         n++;
         if (n > 50) begin
            check("send timeout", 1, 0);
            in_valid = 1'b0;
            return;
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy) begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            check("idle timeout", 1, 0);
            return;
         end
      end
      @(negedge clk);
   endtask

   // Monitor: compare the presented bit against the scoreboard front; pop it
   // only when the downstream consumes it, so stall cycles must hold it.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && serial_valid) begin
            run_len++;
            if (exp_q.size() == 0) begin
               check("unexpected serial bit", 1, 0);
            end else begin
               check("serial_out",  serial_out,  exp_q[0].b);
               check("frame_start", frame_start, exp_q[0].fs);
               check("frame_end",   frame_end,   exp_q[0].fe);
               if (ser_en) void'(exp_q.pop_front());
            end
         end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            check("idle outputs", {serial_out, serial_valid, frame_start, frame_end}, 4'b0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int k;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_data      = 8'h00;
      in_lsb_first = 1'b0;
      ser_en       = 1'b1;
      #1;
      check("reset busy", busy, 0);
      check("reset serial_valid", serial_valid, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post-reset in_ready", in_ready, 1);
      check("post-reset busy", busy, 0);

      // Single word, LSB first.
      @(posedge clk); #1;
      send(8'hA5, 1'b1);
      wait_idle();
      check("A5 lsb run length", last_run, 8);

      // MSB-first word, then 8'h01 back-to-back.
      @(posedge clk); #1;
      send(8'hA5, 1'b0);
      send(8'h01, 1'b0);
      wait_idle();
      check("A5/01 contiguous run", last_run, 16);

      // Three words with valid held: second buffered, third waits.
      @(posedge clk); #1;
      send(8'h3C, 1'b1);
      send(8'h96, 1'b0);
      @(negedge clk);
      check("in_ready while buffer full", in_ready, 0);
      check("busy while buffer full", busy, 1);
      send(8'h5A, 1'b1);
      wait_idle();
      check("three-word contiguous run", last_run, 24);

      // Stall pattern on ser_en during 8'hC3.
      @(posedge clk); #1;
      send(8'hC3, 1'b0);
      k = 0;
      while (busy && k < 100) begin
         ser_en = pat[k % 4];
         @(posedge clk); #1;
         k++;
      end
      check("stall word finished", busy, 0);
      ser_en = 1'b1;
      @(negedge clk);
      check("stall word fully consumed", exp_q.size(), 0);

      // Bypass: new word arrives exactly on the last-bit cycle.
      @(posedge clk); #1;
      send(8'h3C, 1'b1);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!frame_end && k < 50);
      check("bypass reached last bit", frame_end, 1);
      check("bypass in_ready", in_ready, 1);
      in_valid     = 1'b1;
      in_data      = 8'h96;
      in_lsb_first = 1'b0;
      push_word(8'h96, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bypass first bit valid", serial_valid, 1);
      check("bypass frame_start", frame_start, 1);
      wait_idle();
      check("bypass contiguous run", last_run, 16);

      // Reset mid-word with the buffer full.
      @(posedge clk); #1;
      send(8'hFF, 1'b1);
      send(8'h81, 1'b0);
      repeat (4) @(negedge clk);
      check("pre-reset buffer full", in_ready, 0);
      check("pre-reset serial_valid", serial_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset outputs",
            {serial_out, serial_valid, frame_start, frame_end, busy}, 5'b0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("release in_ready", in_ready, 1);
      check("release busy", busy, 0);
      repeat (12) @(negedge clk);
      check("no residual bits", serial_valid, 0);
      check("scoreboard drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_par_to_ser_stream
